// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the single acc/ack access port of sdram_ctrl between
// NUM_PORTS requesters. Winner is chosen by round-robin or fixed priority,
// its command is latched onto the controller port, and the controller's ack
// and read data are returned to the granted requester only.
// Also holds sdram_arbiter_chk, a simulation-only property checker that a
// bench may instantiate alongside the arbiter.

module sdram_arbiter #(
    parameter int NUM_PORTS  = 3,
    parameter int ADR_WIDTH  = 32,
    parameter int DAT_WIDTH  = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic                           sdram_clk,
    input  logic                           sdram_rst,
    input  logic [NUM_PORTS-1:0]           req_acc_i,
    input  logic [NUM_PORTS-1:0]           req_we_i,
    input  logic [NUM_PORTS*ADR_WIDTH-1:0] req_adr_i,
    input  logic [NUM_PORTS*DAT_WIDTH-1:0] req_dat_i,
    input  logic [NUM_PORTS*2-1:0]         req_sel_i,
    output logic [NUM_PORTS-1:0]           req_ack_o,
    output logic [DAT_WIDTH-1:0]           req_dat_o,
    output logic [NUM_PORTS-1:0]           grant_o,
    output logic                           busy_o,
    input  logic                           sc_idle_i,
    output logic [ADR_WIDTH-1:0]           sc_adr_o,
    output logic [DAT_WIDTH-1:0]           sc_dat_o,
    output logic [1:0]                     sc_sel_o,
    output logic                           sc_we_o,
    output logic                           sc_acc_o,
    input  logic                           sc_ack_i,
    input  logic [DAT_WIDTH-1:0]           sc_dat_i
);

    // Port index width (NUM_PORTS is 2..4) and one extra bit for wrap arithmetic.
    localparam int PW = (NUM_PORTS > 2) ? 2 : 1;
    localparam int CW = PW + 1;
    localparam logic [NUM_PORTS-1:0] ONE_P = {{(NUM_PORTS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_ARB      = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_RELEASE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [PW-1:0]          idx_q, idx_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [NUM_PORTS-1:0]   ack_q, ack_d;
    logic                   busy_q, busy_d;
    logic                   acc_q, acc_d;
    logic                   we_q, we_d;
    logic [ADR_WIDTH-1:0]   adr_q, adr_d;
    logic [DAT_WIDTH-1:0]   dat_q, dat_d;
    logic [1:0]             sel_q, sel_d;
    logic [DAT_WIDTH-1:0]   rdat_q, rdat_d;

    logic                   win_found_s;
    logic [PW-1:0]          win_idx_s;
    logic [CW-1:0]          cand_s;
    logic [ADR_WIDTH-1:0]   win_adr_s;
    logic [DAT_WIDTH-1:0]   win_dat_s;
    logic [1:0]             win_sel_s;
    logic                   win_we_s;

    // Winner search: from index 0 (fixed priority) or from the pointer with wrap (round-robin).
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (FIXED_PRIO != 0) begin
                cand_s = CW'(i);
            end else begin
                cand_s = CW'(ptr_q) + CW'(i);
            end
            if (cand_s >= CW'(NUM_PORTS)) begin
                cand_s = cand_s - CW'(NUM_PORTS);
            end else begin
                cand_s = cand_s;
            end
            if (!win_found_s && req_acc_i[cand_s[PW-1:0]]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s[PW-1:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Mux out the winning port's command fields.
    always_comb begin
        win_adr_s = req_adr_i[win_idx_s*ADR_WIDTH +: ADR_WIDTH];
        win_dat_s = req_dat_i[win_idx_s*DAT_WIDTH +: DAT_WIDTH];
        win_sel_s = req_sel_i[win_idx_s*2 +: 2];
        win_we_s  = req_we_i[win_idx_s];
    end

    // Next-state and registered-output logic; everything holds unless a state acts.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        ack_d   = ack_q;
        busy_d  = busy_q;
        acc_d   = acc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        rdat_d  = rdat_q;
        case (state_q)
            ST_ARB: begin
                if (sc_idle_i && win_found_s) begin
                    idx_d   = win_idx_s;
                    adr_d   = win_adr_s;
                    dat_d   = win_dat_s;
                    sel_d   = win_sel_s;
                    we_d    = win_we_s;
                    acc_d   = 1'b1;
                    busy_d  = 1'b1;
                    grant_d = ONE_P << win_idx_s;
                    state_d = ST_WAIT_ACK;
                end else begin
                    acc_d   = 1'b0;
                    state_d = ST_ARB;
                end
            end
            ST_WAIT_ACK: begin
                // Latched command stays on the controller port until the ack.
                if (sc_ack_i) begin
                    acc_d   = 1'b0;
                    we_d    = 1'b0;
                    rdat_d  = sc_dat_i;
                    ack_d   = ONE_P << idx_q;
                    ptr_d   = (idx_q == PW'(NUM_PORTS-1)) ? '0 : idx_q + PW'(1);
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_RELEASE: begin
                ack_d   = '0;
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = ST_ARB;
            end
            default: begin
                ack_d   = '0;
                grant_d = '0;
                busy_d  = 1'b0;
                acc_d   = 1'b0;
                we_d    = 1'b0;
                state_d = ST_ARB;
            end
        endcase
    end

    // State and output registers; reset clears everything, abandoning any access.
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            state_q <= ST_ARB;
            ptr_q   <= '0;
            idx_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            acc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= 2'b00;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            acc_q   <= acc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            rdat_q  <= rdat_d;
        end
    end

    assign req_ack_o = ack_q;
    assign req_dat_o = rdat_q;
    assign grant_o   = grant_q;
    assign busy_o    = busy_q;
    assign sc_adr_o  = adr_q;
    assign sc_dat_o  = dat_q;
    assign sc_sel_o  = sel_q;
    assign sc_we_o   = we_q;
    assign sc_acc_o  = acc_q;

endmodule

// Simulation-only properties of the arbiter outputs.
module sdram_arbiter_chk #(
    parameter int NUM_PORTS = 3
) (
    input logic                 clk_i,
    input logic                 rst_i,
    input logic [NUM_PORTS-1:0] grant_i,
    input logic [NUM_PORTS-1:0] ack_i,
    input logic                 acc_i,
    input logic                 busy_i
);
    a_grant_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(grant_i));
    a_acc_busy:      assert property (@(posedge clk_i) disable iff (rst_i) acc_i |-> busy_i);
    a_ack_in_grant:  assert property (@(posedge clk_i) disable iff (rst_i) (ack_i & ~grant_i) == '0);
endmodule
